// File: rtl/glyph_rom_arbiter.sv
// Two-port arbiter in front of a single-port glyph ROM/BRAM with a 1-cycle read.
// Port A (pixel path) has priority; port B (background) gets a starvation guard.
module glyph_rom_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_we,
    output logic [DATA_W-1:0] rom_din,
    input  logic [DATA_W-1:0] rom_dout
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_e;

    logic [CNT_W-1:0] starve_q, starve_d;
    owner_e           owner_q, owner_d;
    logic             b_force;

    // Grants stay low during reset so nothing reaches the ROM while rstn is low.
    assign b_force = b_req && (starve_q == CNT_MAX);
    assign a_gnt   = rstn && a_req && !b_force;
    assign b_gnt   = rstn && b_req && (b_force || !a_req);

    assign rom_addr = a_gnt ? a_addr : (b_gnt ? b_addr : '0);
    assign rom_we   = b_gnt && b_we;
    assign rom_din  = b_gnt ? b_wdata : '0;

    always_comb begin
        starve_d = starve_q;
        if (!b_req || b_gnt)
            starve_d = '0;
        else if (starve_q != CNT_MAX)
            starve_d = starve_q + 1'b1;
    end

    // Writes tag OWN_NONE so the return path only fires for reads.
    always_comb begin
        owner_d = OWN_NONE;
        if (a_gnt)
            owner_d = OWN_A;
        else if (b_gnt && !b_we)
            owner_d = OWN_B;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_q <= '0;
            owner_q  <= OWN_NONE;
        end else begin
            starve_q <= starve_d;
            owner_q  <= owner_d;
        end
    end

    assign a_rvalid = (owner_q == OWN_A);
    assign b_rvalid = (owner_q == OWN_B);
    assign a_rdata  = a_rvalid ? rom_dout : '0;
    assign b_rdata  = b_rvalid ? rom_dout : '0;
endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// Directed bench for glyph_rom_arbiter with a behavioural 1-cycle ROM/BRAM model.
module tb_glyph_rom_arbiter;
    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          a_req, a_gnt, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_rdata;
    logic          b_req, b_we, b_gnt, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic [AW-1:0] rom_addr;
    logic          rom_we;
    logic [DW-1:0] rom_din, rom_dout;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    glyph_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rstn(rstn),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .rom_addr(rom_addr), .rom_we(rom_we), .rom_din(rom_din), .rom_dout(rom_dout)
    );

    // Unwritten lines read back as A000 ^ addr.
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic          written [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (rom_we) begin
            mem[rom_addr]     <= rom_din;
            written[rom_addr] <= 1'b1;
        end
        rom_dout <= (written[rom_addr] === 1'b1) ? mem[rom_addr] : (16'hA000 ^ DW'(rom_addr));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; a_req = 1'b1; a_addr = '0;
        b_req = 1'b1; b_we = 1'b1; b_addr = 12'h001; b_wdata = 16'h1234;

        // 1. reset holds everything quiet
        @(negedge clk);
        chk("rst a_gnt", a_gnt, 0);
        chk("rst b_gnt", b_gnt, 0);
        chk("rst a_rvalid", a_rvalid, 0);
        chk("rst b_rvalid", b_rvalid, 0);
        chk("rst a_rdata", a_rdata, 0);
        chk("rst b_rdata", b_rdata, 0);
        chk("rst rom_we", rom_we, 0);
        nxt();
        rstn = 1'b1; b_req = 1'b0; b_we = 1'b0;

        // 2. A-only stream 0..3
        for (int i = 0; i < 4; i++) begin
            a_addr = AW'(i);
            @(negedge clk);
            chk("A stream gnt", a_gnt, 1);
            chk("A stream addr", rom_addr, i);
            if (i > 0) begin
                chk("A stream rvalid", a_rvalid, 1);
                chk("A stream rdata", a_rdata, 16'hA000 ^ (i - 1));
            end
            nxt();
        end
        a_req = 1'b0;
        @(negedge clk);
        chk("A stream last rvalid", a_rvalid, 1);
        chk("A stream last rdata", a_rdata, 16'hA003);
        chk("idle rom_addr", rom_addr, 0);
        nxt();
        @(negedge clk);
        chk("A stream done rvalid", a_rvalid, 0);
        nxt();

        // 3. contention: B granted on the 9th cycle
        a_req = 1'b1; a_addr = 12'h100;
        b_req = 1'b1; b_we = 1'b0; b_addr = 12'h010;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk("cont b_gnt", b_gnt, (c == 9));
            chk("cont a_gnt", a_gnt, (c != 9));
            nxt();
        end
        b_req = 1'b0;
        @(negedge clk);
        chk("cont b_rvalid", b_rvalid, 1);
        chk("cont b_rdata", b_rdata, 16'hA010);
        chk("cont a_rvalid", a_rvalid, 0);
        chk("cont a_gnt after", a_gnt, 1);
        nxt();
        a_req = 1'b0;
        nxt();

        // 4. B write then read of the same line
        b_req = 1'b1; b_we = 1'b1; b_addr = 12'h020; b_wdata = 16'h5A5A;
        @(negedge clk);
        chk("wr b_gnt", b_gnt, 1);
        chk("wr rom_we", rom_we, 1);
        chk("wr rom_din", rom_din, 16'h5A5A);
        chk("wr rom_addr", rom_addr, 12'h020);
        nxt();
        b_we = 1'b0;
        @(negedge clk);
        chk("wr no rvalid", b_rvalid, 0);
        chk("rd rom_we", rom_we, 0);
        chk("rd b_gnt", b_gnt, 1);
        nxt();
        b_req = 1'b0;
        @(negedge clk);
        chk("rd b_rvalid", b_rvalid, 1);
        chk("rd b_rdata", b_rdata, 16'h5A5A);
        nxt();

        // 5. B withdraws after 5 starved cycles; count restarts
        a_req = 1'b1; a_addr = 12'h200;
        b_req = 1'b1; b_we = 1'b0; b_addr = 12'h030;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("wd b_gnt", b_gnt, 0);
            nxt();
        end
        b_req = 1'b0;
        nxt();
        b_req = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk("rerq b_gnt", b_gnt, (c == 9));
            nxt();
        end
        b_req = 1'b0;
        @(negedge clk);
        chk("rerq b_rdata", b_rdata, 16'hA030);
        nxt();
        a_req = 1'b0;
        nxt();

        // 6. reset right after an A grant drops the read
        a_req = 1'b1; a_addr = 12'h005;
        @(negedge clk);
        chk("rst6 a_gnt", a_gnt, 1);
        nxt();
        a_req = 1'b0; rstn = 1'b0;
        @(negedge clk);
        chk("rst6 a_rvalid", a_rvalid, 0);
        chk("rst6 a_rdata", a_rdata, 0);
        nxt();
        rstn = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst6 post a_rvalid", a_rvalid, 0);
            chk("rst6 post b_rvalid", b_rvalid, 0);
            nxt();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
